// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   state_e   : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   gnt_e     : grant decision encoding (GNT_NONE, GNT_I, GNT_D)
//   CNT_W     : width of the access-latency counter
//   LAT_MIN/LAT_MAX, lat_legal() : legal memory latency range and its check
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int CNT_W   = 3;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    // A latency is legal when it fits the counter without wrapping.
    function automatic bit lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Counts the cycles of one memory access and flags the last one.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at zero (asserted at every grant edge)
//   enable     : count this cycle (asserted while an access is in flight)
//   terminal   : count has reached LAT-1, i.e. this is the done cycle
// An illegal LAT is clamped to LAT_MAX so the counter can never wrap.
// -----------------------------------------------------------------------------
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int              LAT_C  = lat_legal(LAT) ? LAT : LAT_MAX;
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(LAT_C - 1);

    logic [CNT_W-1:0] cnt_r;

    // Access cycle counter: cleared on grant, saturates at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != TERM_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign terminal = (cnt_r == TERM_C);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one multi-cycle unified memory between the instruction-fetch port
// (read-only) and the data port (read/write). Each granted request is latched
// and held on the memory side for the full access latency; read data is
// returned with a one-cycle done pulse to the winning requester.
// Arbitration: data wins on contention, except that a second consecutive data
// grant is refused while a fetch is waiting.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   i_req, i_addr                 : fetch request and address
//   i_done, i_rdata               : fetch done pulse and data (valid with done)
//   d_req, d_wr, d_addr, d_wdata  : data request, write flag, address, data
//   d_done, d_rdata               : data done pulse and read data
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata          : memory interface
//   busy                          : an access is in progress
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_r;
    state_e            state_nxt_s;
    gnt_e              gnt_s;
    logic              last_d_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wr_r;
    logic              term_s;
    logic              busy_s;
    logic              done_s;
    logic              cnt_clear_s;

    assign busy_s      = (state_r != IDLE);
    assign done_s      = busy_s && term_s;
    assign cnt_clear_s = (gnt_s != GNT_NONE);

    mem_lat_counter #(
        .LAT (LAT)
    ) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .enable   (busy_s),
        .terminal (term_s)
    );

    // Grant decision: evaluated in IDLE and in the done cycle so that
    // back-to-back accesses run without an idle cycle in between.
    always_comb begin
        gnt_s = GNT_NONE;
        if ((state_r == IDLE) || done_s) begin
            if (d_req && !(i_req && last_d_r)) begin
                gnt_s = GNT_D;
            end else if (i_req) begin
                gnt_s = GNT_I;
            end else begin
                gnt_s = GNT_NONE;
            end
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Next state: a new grant always wins; otherwise finish or keep waiting.
    always_comb begin
        state_nxt_s = state_r;
        case (gnt_s)
            GNT_D:    state_nxt_s = BUSY_D;
            GNT_I:    state_nxt_s = BUSY_I;
            GNT_NONE: state_nxt_s = done_s ? IDLE : state_r;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch: captures the winner's fields at the grant edge only, so
    // later requester changes cannot disturb the access in flight. A fetch
    // never writes, so its grant forces the latched write flag low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            wr_r     <= 1'b0;
            last_d_r <= 1'b0;
        end else begin
            case (gnt_s)
                GNT_D: begin
                    addr_r   <= d_addr;
                    wdata_r  <= d_wdata;
                    wr_r     <= d_wr;
                    last_d_r <= 1'b1;
                end
                GNT_I: begin
                    addr_r   <= i_addr;
                    wdata_r  <= wdata_r;
                    wr_r     <= 1'b0;
                    last_d_r <= 1'b0;
                end
                default: begin
                    addr_r   <= addr_r;
                    wdata_r  <= wdata_r;
                    wr_r     <= wr_r;
                    last_d_r <= last_d_r;
                end
            endcase
        end
    end

    // Output decode: memory side is driven only while busy; read data is a
    // pass-through of the memory bus during the done cycle of the owning port.
    always_comb begin
        mem_en  = 1'b0;
        mem_wr  = 1'b0;
        busy    = 1'b0;
        i_done  = 1'b0;
        d_done  = 1'b0;
        i_rdata = {DATA_W{1'b0}};
        d_rdata = {DATA_W{1'b0}};
        case (state_r)
            BUSY_I: begin
                mem_en = 1'b1;
                busy   = 1'b1;
                mem_wr = wr_r;
                i_done = term_s;
                if (term_s) begin
                    i_rdata = mem_rdata;
                end else begin
                    i_rdata = {DATA_W{1'b0}};
                end
            end
            BUSY_D: begin
                mem_en = 1'b1;
                busy   = 1'b1;
                mem_wr = wr_r;
                d_done = term_s;
                if (term_s) begin
                    d_rdata = mem_rdata;
                end else begin
                    d_rdata = {DATA_W{1'b0}};
                end
            end
            default: begin
                mem_en = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule
